// File: rtl/prog_sequencer.sv
// prog_sequencer: fetch-side PC and program-state sequencer.
// Runs programs 1..3 in turn, then drops back to idle.
// Ports:
//   CLK, Reset (async, active-high)
//   Start, Halt, BranchEn, BranchTarget[9:0] : control inputs
//   PC[9:0], ProgState[1:0], Running, Done,
//   CycleCount[15:0] : registered status (Running is derived)
module prog_sequencer #(
  parameter logic [9:0] P1_START = 10'd0,
  parameter logic [9:0] P2_START = 10'd64,
  parameter logic [9:0] P3_START = 10'd256
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Halt,
  input  logic        BranchEn,
  input  logic [9:0]  BranchTarget,
  output logic [9:0]  PC,
  output logic [1:0]  ProgState,
  output logic        Running,
  output logic        Done,
  output logic [15:0] CycleCount
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_P1   = 2'b01;
  localparam logic [1:0] S_P2   = 2'b10;
  localparam logic [1:0] S_P3   = 2'b11;

  logic        idle;
  logic [15:0] cnt_inc;

  assign idle    = (ProgState == S_IDLE);
  assign Running = !idle && !Done;

  // Saturating increment: holds at all-ones.
  assign cnt_inc = (CycleCount == 16'hFFFF)
                 ? CycleCount
                 : CycleCount + 16'd1;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      PC         <= 10'd0;
      ProgState  <= S_IDLE;
      Done       <= 1'b0;
      CycleCount <= 16'd0;
    end else if (idle) begin
      if (Start) begin
        ProgState  <= S_P1;
        PC         <= P1_START;
        Done       <= 1'b0;
        CycleCount <= 16'd0;
      end
    end else if (!Done) begin
      CycleCount <= cnt_inc;
      if (Halt) begin
        Done <= 1'b1;
      end else if (BranchEn) begin
        PC <= BranchTarget;
      end else begin
        PC <= PC + 10'd1;
      end
    end else if (Start) begin
      Done       <= 1'b0;
      CycleCount <= 16'd0;
      unique case (ProgState)
        S_P1: begin
          ProgState <= S_P2;
          PC        <= P2_START;
        end
        S_P2: begin
          ProgState <= S_P3;
          PC        <= P3_START;
        end
        default: begin
          ProgState <= S_IDLE;
          PC        <= 10'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed + random stimulus for prog_sequencer,
// checked against a program-level reference model.
module tb_prog_sequencer;

  logic        CLK;
  logic        Reset;
  logic        Start;
  logic        Halt;
  logic        BranchEn;
  logic [9:0]  BranchTarget;
  logic [9:0]  PC;
  logic [1:0]  ProgState;
  logic        Running;
  logic        Done;
  logic [15:0] CycleCount;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_prog;
  int m_pc;
  int m_done;
  int m_cnt;
  int starts [4] = '{0, 0, 64, 256};

  prog_sequencer dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .Start        (Start),
    .Halt         (Halt),
    .BranchEn     (BranchEn),
    .BranchTarget (BranchTarget),
    .PC           (PC),
    .ProgState    (ProgState),
    .Running      (Running),
    .Done         (Done),
    .CycleCount   (CycleCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"},   {22'd0, PC},         m_pc);
    chk({tag, ".ps"},   {30'd0, ProgState},  m_prog);
    chk({tag, ".done"}, {31'd0, Done},       m_done);
    chk({tag, ".cnt"},  {16'd0, CycleCount}, m_cnt);
    chk({tag, ".run"},  {31'd0, Running},
        (m_prog != 0 && m_done == 0) ? 1 : 0);
  endtask

  task automatic model_reset();
    m_prog = 0;
    m_pc   = 0;
    m_done = 0;
    m_cnt  = 0;
  endtask

  // One clock edge of the program-level behaviour.
  task automatic model_step(input int s, input int h,
                            input int b, input int t);
    if (m_prog == 0) begin
      if (s != 0) begin
        m_prog = 1;
        m_pc   = starts[1];
        m_done = 0;
        m_cnt  = 0;
      end
    end else if (m_done == 0) begin
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (h != 0)      m_done = 1;
      else if (b != 0) m_pc = t;
      else             m_pc = (m_pc + 1) % 1024;
    end else if (s != 0) begin
      m_prog = (m_prog + 1) % 4;
      m_pc   = starts[m_prog];
      m_done = 0;
      m_cnt  = 0;
    end
  endtask

  // Drive on negedge, step one rising edge, optionally check.
  task automatic cyc(input int s, input int h, input int b,
                     input int t, input bit check, input string tag);
    @(negedge CLK);
    Start        = s[0];
    Halt         = h[0];
    BranchEn     = b[0];
    BranchTarget = t[9:0];
    @(posedge CLK);
    #1;
    model_step(s, h, b, t);
    if (check) chk_all(tag);
  endtask

  initial begin
    int n;
    int s, h, b, t;

    Reset        = 1'b1;
    Start        = 1'b0;
    Halt         = 1'b0;
    BranchEn     = 1'b0;
    BranchTarget = 10'd0;
    model_reset();
    @(posedge CLK);
    #1;
    chk_all("reset");
    @(negedge CLK);
    Reset = 1'b0;
    cyc(0, 1, 1, 5, 1, "idle_ignore");

    // reset mid-run
    cyc(1, 0, 0, 0, 1, "rst_start");
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, "rst_run");
    @(negedge CLK);
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    chk_all("rst_async");
    @(posedge CLK);
    #1;
    chk_all("rst_hold");
    @(negedge CLK);
    Reset = 1'b0;

    // straight-line program 1, with ignored Start pulses
    cyc(1, 0, 0, 0, 1, "p1_start");
    chk("p1_first_pc", {22'd0, PC}, 0);
    n = 0;
    while (m_pc != 44 && n < 100) begin
      s = ($urandom_range(0, 7) == 0) ? 1 : 0;
      cyc(s, 0, 0, 0, 1, "p1_run");
      n++;
    end
    cyc(0, 1, 0, 0, 1, "p1_halt");
    chk("p1_pc", {22'd0, PC}, 44);
    chk("p1_cnt", {16'd0, CycleCount}, 45);
    chk("p1_running", {31'd0, Running}, 0);
    for (int i = 0; i < 3; i++)
      cyc(0, $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1023), 1, "p1_done_hold");

    // program 2: branch then halt+branch priority
    cyc(1, 0, 0, 0, 1, "p2_start");
    chk("p2_first_pc", {22'd0, PC}, 64);
    cyc(0, 0, 0, 0, 1, "p2_run");
    cyc(0, 0, 0, 0, 1, "p2_run");
    cyc(0, 0, 1, 103, 1, "p2_branch");
    chk("p2_br_pc", {22'd0, PC}, 103);
    cyc(0, 1, 1, 500, 1, "p2_prio");
    chk("p2_prio_pc", {22'd0, PC}, 103);
    chk("p2_prio_done", {31'd0, Done}, 1);

    // program 3: random run, then wrap 1023 -> 0
    cyc(1, 0, 0, 0, 1, "p3_start");
    chk("p3_first_pc", {22'd0, PC}, 256);
    for (int i = 0; i < 20; i++) begin
      b = ($urandom_range(0, 3) == 0) ? 1 : 0;
      s = ($urandom_range(0, 3) == 0) ? 1 : 0;
      cyc(s, 0, b, $urandom_range(0, 1023), 1, "p3_rand");
    end
    cyc(0, 0, 1, 1023, 1, "p3_br1023");
    chk("wrap_hi", {22'd0, PC}, 1023);
    cyc(0, 0, 0, 0, 1, "p3_wrap");
    chk("wrap_lo", {22'd0, PC}, 0);
    cyc(0, 1, 0, 0, 1, "p3_halt");
    cyc(1, 0, 0, 0, 1, "p3_to_idle");
    chk("idle_ps", {30'd0, ProgState}, 0);
    chk("idle_pc", {22'd0, PC}, 0);

    // full sequence, 3 instructions each
    for (int p = 1; p <= 3; p++) begin
      cyc(1, 0, 0, 0, 1, "seq_start");
      chk("seq_ps", {30'd0, ProgState}, p);
      chk("seq_pc", {22'd0, PC}, starts[p]);
      cyc(0, 0, 0, 0, 1, "seq_i1");
      cyc(0, 0, 0, 0, 1, "seq_i2");
      cyc(0, 1, 0, 0, 1, "seq_halt");
      chk("seq_cnt", {16'd0, CycleCount}, 3);
    end
    cyc(1, 0, 0, 0, 1, "seq_end");
    chk("seq_final_ps", {30'd0, ProgState}, 0);
    chk("seq_final_pc", {22'd0, PC}, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 4) == 0) ? 1 : 0;
      h = ($urandom_range(0, 15) == 0) ? 1 : 0;
      b = ($urandom_range(0, 7) == 0) ? 1 : 0;
      t = $urandom_range(0, 1023);
      cyc(s, h, b, t, 1, "rand");
    end

    // saturation: get into a running program first
    n = 0;
    while (!(m_prog != 0 && m_done == 0) && n < 10) begin
      cyc(1, 0, 0, 0, 1, "sat_enter");
      n++;
    end
    for (int i = 0; i < 70000; i++)
      cyc(0, 0, 0, 0, (i % 5000) == 0, "sat_run");
    chk_all("sat_end");
    chk("sat_cnt", {16'd0, CycleCount}, 32'hFFFF);
    cyc(0, 0, 0, 0, 1, "sat_hold");
    chk("sat_cnt2", {16'd0, CycleCount}, 32'hFFFF);
    cyc(0, 1, 0, 0, 1, "sat_halt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
